// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU mode codes and width default
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;
   localparam logic [2:0] ALU_SHL = 3'b110;
   localparam logic [2:0] ALU_SHR = 3'b111;

endpackage

// File: rtl/alu_8bit_if.sv
// rtl/alu_8bit_if.sv - operand/mode/result bundle between datapath control and the ALU
interface alu_8bit_if
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) ();

   logic             en;
   logic [2:0]       mode;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] sum;
   logic             fz;
   logic             fc;

   modport master (
      output en, mode, in_a, in_b,
      input  sum, fz, fc
   );

   modport slave (
      input  en, mode, in_a, in_b,
      output sum, fz, fc
   );

endinterface

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational ALU core producing result and carry
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r,
   output logic             c
);

   // One extra bit holds carry-out on add and borrow on subtract.
   logic [WIDTH:0] ext;

   always_comb begin
      ext = '0;
      r   = '0;
      c   = 1'b0;
      case (mode)
         ALU_ADD: begin
            ext = {1'b0, a} + {1'b0, b};
            r   = ext[WIDTH-1:0];
            c   = ext[WIDTH];
         end
         ALU_SUB: begin
            ext = {1'b0, a} - {1'b0, b};
            r   = ext[WIDTH-1:0];
            c   = ext[WIDTH];
         end
         ALU_AND: r = a & b;
         ALU_OR:  r = a | b;
         ALU_XOR: r = a ^ b;
         ALU_NOT: r = ~a;
         ALU_SHL: begin
            r = {a[WIDTH-2:0], 1'b0};
            c = a[WIDTH-1];
         end
         ALU_SHR: begin
            r = {1'b0, a[WIDTH-1:1]};
            c = a[0];
         end
         default: begin
            r = '0;
            c = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - registered ALU with enable, zero and carry flags
module alu_8bit
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   alu_8bit_if.slave  bus
);

   logic [WIDTH-1:0] r;
   logic             c;
   logic [WIDTH-1:0] sum_q;
   logic             fz_q;
   logic             fc_q;

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .mode (bus.mode),
      .a    (bus.in_a),
      .b    (bus.in_b),
      .r    (r),
      .c    (c)
   );

   // Zero flag is derived from the same r being captured, so it never lags sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         fz_q  <= 1'b0;
         fc_q  <= 1'b0;
      end else if (bus.en) begin
         sum_q <= r;
         fz_q  <= (r == '0);
         fc_q  <= c;
      end
   end

   assign bus.sum = sum_q;
   assign bus.fz  = fz_q;
   assign bus.fc  = fc_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - randomized and directed checks of alu_8bit against a behavioural model
module tb_alu_8bit;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   exp_sum;
   int   exp_fz;
   int   exp_fc;

   alu_8bit_if #(.WIDTH(8)) bus ();

   alu_8bit #(
      .WIDTH (8)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void ref_alu(input int m, input int a, input int b,
                                   output int r, output int cy);
      cy = 0;
      case (m)
         0: begin r = (a + b) % 256;       cy = (a + b > 255) ? 1 : 0; end
         1: begin r = (a - b + 256) % 256; cy = (a < b) ? 1 : 0; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = 255 - a;
         6: begin r = (a * 2) % 256;       cy = a / 128; end
         default: begin r = a / 2;         cy = a % 2; end
      endcase
   endfunction

   task automatic check_model(input string tag);
      check({tag, "_sum"}, bus.sum, exp_sum);
      check({tag, "_fz"},  bus.fz,  exp_fz);
      check({tag, "_fc"},  bus.fc,  exp_fc);
   endtask

   task automatic step(input string tag, input bit e, input int m, input int a, input int b);
      int r;
      int cy;
      @(negedge clk);
      bus.en   = e;
      bus.mode = 3'(m);
      bus.in_a = 8'(a);
      bus.in_b = 8'(b);
      @(posedge clk);
      #1;
      if (e) begin
         ref_alu(m, a, b, r, cy);
         exp_sum = r;
         exp_fz  = (r == 0) ? 1 : 0;
         exp_fc  = cy;
      end
      check_model(tag);
   endtask

   task automatic expect_out(input string tag, input int s, input int z, input int cy);
      check({tag, "_k_sum"}, bus.sum, s);
      check({tag, "_k_fz"},  bus.fz,  z);
      check({tag, "_k_fc"},  bus.fc,  cy);
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      exp_sum  = 0;
      exp_fz   = 0;
      exp_fc   = 0;
      rst_n    = 1'b0;
      bus.en   = 1'b1;
      bus.mode = 3'b000;
      bus.in_a = 8'd5;
      bus.in_b = 8'd13;

      repeat (3) @(posedge clk);
      #1;
      expect_out("reset_hold", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      step("add_5_13", 1, 0, 5, 13);     expect_out("add_5_13", 18, 0, 0);
      step("add_200_100", 1, 0, 200, 100); expect_out("add_200_100", 44, 0, 1);
      step("add_wrap", 1, 0, 255, 1);    expect_out("add_wrap", 0, 1, 1);

      step("sub_13_5", 1, 1, 13, 5);     expect_out("sub_13_5", 8, 0, 0);
      step("sub_5_13", 1, 1, 5, 13);     expect_out("sub_5_13", 248, 0, 1);
      step("sub_7_7", 1, 1, 7, 7);       expect_out("sub_7_7", 0, 1, 0);
      step("sub_0_1", 1, 1, 0, 1);       expect_out("sub_0_1", 255, 0, 1);

      step("and", 1, 2, 8'hF0, 8'h3C);   expect_out("and", 8'h30, 0, 0);
      step("or",  1, 3, 8'hF0, 8'h3C);   expect_out("or",  8'hFC, 0, 0);
      step("xor", 1, 4, 8'hF0, 8'h3C);   expect_out("xor", 8'hCC, 0, 0);
      step("not", 1, 5, 8'hF0, 8'h3C);   expect_out("not", 8'h0F, 0, 0);
      step("and_zero", 1, 2, 8'hF0, 8'h0F); expect_out("and_zero", 0, 1, 0);

      step("shl", 1, 6, 8'h81, 8'hAA);   expect_out("shl", 8'h02, 0, 1);
      step("shr", 1, 7, 8'h81, 8'h55);   expect_out("shr", 8'h40, 0, 1);
      step("shl_80", 1, 6, 8'h80, 8'h00); expect_out("shl_80", 0, 1, 1);

      step("hold_load", 1, 0, 5, 13);
      for (int i = 0; i < 3; i++) begin
         step("hold", 0, 1, 1, 2);
         expect_out("hold", 18, 0, 0);
      end
      step("hold_release", 1, 1, 1, 2); expect_out("hold_release", 255, 0, 1);

      // Asynchronous reset between clock edges must clear the outputs at once.
      step("pre_async", 1, 0, 5, 13);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0);
      exp_sum = 0;
      exp_fz  = 0;
      exp_fc  = 0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         step("rand", ($urandom % 4) != 0, int'($urandom % 8),
              int'($urandom % 256), int'($urandom % 256));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
